// File: rtl/twos_complement_seq.sv
`default_nettype none
// ============================================================================
// Module   : twos_complement_seq
// Brief    : Digit-serial pass / negate / absolute-value unit, D bits per cycle.
//            Define TWOS_COMPLEMENT_SAT_EN to saturate the overflow result.
// Revision : 1.0
// ============================================================================
module twos_complement_seq #(
    parameter int N = 8,
    parameter int D = 4
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic [N-1:0] In,
    input  logic [1:0]   Mode,
    input  logic         In_Valid,
    output logic         In_Ready,
    output logic [N-1:0] Out,
    output logic         Ovf,
    output logic         Out_Valid,
    input  logic         Out_Ready
);

    localparam int K  = N / D;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    localparam logic [CW-1:0] c_last_digit = CW'(K - 1);
    localparam logic [N-1:0]  c_min_neg    = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  c_max_pos    = {1'b0, {(N-1){1'b1}}};

`ifdef TWOS_COMPLEMENT_SAT_EN
    localparam logic c_sat_en = 1'b1;
`else
    localparam logic c_sat_en = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [N-1:0]    r_operand;
    logic [N-1:0]    r_result;
    logic            r_flip;
    logic            r_carry;
    logic            r_ovf;
    logic            r_ovf_pend;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_last;
    logic            w_flip_in;
    logic [D-1:0]    w_digit;
    logic [D:0]      w_sum;
    logic [N-1:0]    w_result_shift;
    logic [N-1:0]    w_operand_shift;

    assign w_accept = (r_state == S_IDLE) && In_Valid;
    assign w_last   = (r_state == S_RUN) && (r_cnt == c_last_digit);

    always_comb begin
        w_flip_in = 1'b0;
        case (Mode)
            2'b01:   w_flip_in = 1'b1;
            2'b10:   w_flip_in = In[N-1];
            default: w_flip_in = 1'b0;
        endcase
    end

    // Operand is consumed from the bottom; result digits enter from the top.
    assign w_digit = r_operand[D-1:0] ^ {D{r_flip}};
    assign w_sum   = {1'b0, w_digit} + {{D{1'b0}}, r_carry};

    generate
        if (K == 1) begin : g_single
            assign w_result_shift  = w_sum[D-1:0];
            assign w_operand_shift = '0;
        end else begin : g_multi
            assign w_result_shift  = {w_sum[D-1:0], r_result[N-1:D]};
            assign w_operand_shift = {{D{1'b0}}, r_operand[N-1:D]};
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (In_Valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (Out_Ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_operand  <= '0;
            r_result   <= '0;
            r_flip     <= 1'b0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_operand  <= In;
            r_flip     <= w_flip_in;
            r_carry    <= w_flip_in;
            r_ovf_pend <= w_flip_in && (In == c_min_neg);
            r_cnt      <= '0;
        end else if (r_state == S_RUN) begin
            r_operand <= w_operand_shift;
            r_carry   <= w_sum[D];
            r_cnt     <= r_cnt + CW'(1);
            if (w_last) begin
                // Only -2^(N-1) can overflow, so the saturated value replaces it whole.
                r_ovf    <= r_ovf_pend;
                r_result <= (c_sat_en && r_ovf_pend) ? c_max_pos : w_result_shift;
            end else begin
                r_result <= w_result_shift;
            end
        end
    end

    assign In_Ready  = (r_state == S_IDLE);
    assign Out_Valid = (r_state == S_DONE);
    assign Out       = r_result;
    assign Ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_twos_complement_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_twos_complement_seq
// Brief    : Self-checking bench for twos_complement_seq (N=8, D=4).
// Revision : 1.0
// ============================================================================
module tb_twos_complement_seq;

    localparam int N = 8;
    localparam int D = 4;
    localparam int K = N / D;

    logic         Clk = 1'b0;
    logic         Rst_n = 1'b0;
    logic [N-1:0] In = '0;
    logic [1:0]   Mode = 2'b00;
    logic         In_Valid = 1'b0;
    logic         In_Ready;
    logic [N-1:0] Out;
    logic         Ovf;
    logic         Out_Valid;
    logic         Out_Ready = 1'b0;

    twos_complement_seq #(.N(N), .D(D)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .In        (In),
        .Mode      (Mode),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Out       (Out),
        .Ovf       (Ovf),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [N-1:0] out;
        logic         ovf;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    int   lat = 0;
    bit   expecting = 1'b0;
    bit   armed = 1'b0;
    int   accepts = 0;
    int   retires = 0;
    logic exp_valid;

    // Result from signed arithmetic, then reduced to N bits.
    function automatic exp_t model(input logic [N-1:0] a, input logic [1:0] m);
        longint v, r, maxpos;
        exp_t   e;
        v = longint'(a);
        if (a[N-1]) v = v - (longint'(1) << N);
        case (m)
            2'b01:   r = -v;
            2'b10:   r = (v < 0) ? -v : v;
            default: r = v;
        endcase
        maxpos = (longint'(1) << (N - 1)) - 1;
        e.ovf  = (r > maxpos);
        e.out  = r[N-1:0];
`ifdef TWOS_COMPLEMENT_SAT_EN
        if (e.ovf) e.out = maxpos[N-1:0];
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge Clk) begin
        if (!Rst_n) begin
            accepts   = accepts - q.size();
            q.delete();
            expecting = 1'b0;
            armed     = 1'b1;
        end else begin
            if (Out_Valid && Out_Ready) begin
                if (q.size() > 0) void'(q.pop_front());
                retires++;
            end
            if (In_Ready && In_Valid) begin
                q.push_back(model(In, Mode));
                accepts++;
                expecting = 1'b1;
                lat       = 0;
            end else if (expecting) begin
                lat++;
            end
        end
    end

    always @(negedge Clk) begin
        if (armed) begin
            check("in_ready", In_Ready, q.size() == 0);
            exp_valid = (q.size() > 0) && !(expecting && lat < K);
            check("out_valid", Out_Valid, exp_valid);
            if (expecting && lat >= K) expecting = 1'b0;
            if (Out_Valid && q.size() > 0) begin
                check("out", Out, q[0].out);
                check("ovf", Ovf, q[0].ovf);
            end
        end
    end

    task automatic op(input logic [N-1:0] a, input logic [1:0] m, input int hold,
                      output logic [N-1:0] o, output logic ov);
        int t;
        @(negedge Clk);
        In = a; Mode = m; In_Valid = 1'b1; Out_Ready = 1'b0;
        @(negedge Clk);
        In_Valid = 1'b0; In = N'($urandom); Mode = 2'($urandom);
        t = 0;
        while (!Out_Valid && t < 50) begin
            @(negedge Clk);
            t++;
        end
        if (!Out_Valid) begin
            failures++;
            $display("FAIL op_timeout: got no Out_Valid expected Out_Valid within 50 cycles");
        end
        o  = Out;
        ov = Ovf;
        for (int i = 0; i < hold; i++) begin
            In_Valid = i[0];
            @(negedge Clk);
        end
        check("hold_stable", Out, o);
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        @(negedge Clk);
        Out_Ready = 1'b0;
    endtask

    initial begin
        logic [N-1:0] o;
        logic         ov;
        int           start;
        int           cyc;

        check("model_neg05", model(8'h05, 2'b01), {8'hFB, 1'b0});
        check("model_abs_f6", model(8'hF6, 2'b10), {8'h0A, 1'b0});
        check("model_neg00", model(8'h00, 2'b01), {8'h00, 1'b0});
        check("model_rsv_9c", model(8'h9C, 2'b11), {8'h9C, 1'b0});

        // Reset with In_Valid held high: nothing may be accepted.
        Rst_n = 1'b0; In_Valid = 1'b1; In = 8'h55; Mode = 2'b01;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1; In_Valid = 1'b0;
        check("rst_out", Out, 0);
        check("rst_ovf", Ovf, 0);
        check("rst_valid", Out_Valid, 0);
        check("rst_ready", In_Ready, 1);

        op(8'h05, 2'b01, 0, o, ov);
        check("neg05_out", o, 8'hFB);
        check("neg05_ovf", ov, 0);
        op(8'h80, 2'b10, 0, o, ov);
`ifdef TWOS_COMPLEMENT_SAT_EN
        check("abs80_out", o, 8'h7F);
`else
        check("abs80_out", o, 8'h80);
`endif
        check("abs80_ovf", ov, 1);
        op(8'h80, 2'b01, 0, o, ov);
        check("neg80_ovf", ov, 1);
        op(8'hF6, 2'b10, 0, o, ov);
        check("absf6_out", o, 8'h0A);
        check("absf6_ovf", ov, 0);
        op(8'h7F, 2'b10, 0, o, ov);
        check("abs7f_out", o, 8'h7F);
        op(8'h00, 2'b01, 0, o, ov);
        check("neg00_out", o, 8'h00);
        check("neg00_ovf", ov, 0);
        op(8'h9C, 2'b11, 0, o, ov);
        check("rsv9c_out", o, 8'h9C);
        check("rsv9c_ovf", ov, 0);
        op(8'h9C, 2'b00, 0, o, ov);
        check("pass9c_out", o, 8'h9C);
        op(8'h01, 2'b01, 5, o, ov);
        check("bp01_out", o, 8'hFF);

        // Reset while digit 1 is pending.
        @(negedge Clk);
        In = 8'h33; Mode = 2'b01; In_Valid = 1'b1;
        @(negedge Clk);
        In_Valid = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b0; In_Valid = 1'b1;
        @(negedge Clk);
        Rst_n = 1'b1; In_Valid = 1'b0;
        check("abort_valid", Out_Valid, 0);
        check("abort_out", Out, 0);
        check("abort_ovf", Ovf, 0);
        check("abort_ready", In_Ready, 1);
        op(8'h10, 2'b01, 0, o, ov);
        check("neg10_out", o, 8'hF0);

        start = accepts;
        cyc   = 0;
        while ((accepts - start) < 10000 && cyc < 90000) begin
            @(negedge Clk);
            case ($urandom % 8)
                0:       In = 8'h80;
                1:       In = 8'h00;
                2:       In = 8'h7F;
                default: In = N'($urandom);
            endcase
            Mode      = 2'($urandom);
            In_Valid  = ($urandom % 8) != 0;
            Out_Ready = ($urandom % 4) != 0;
            cyc++;
        end
        check("soak_count", (accepts - start) >= 10000, 1);

        @(negedge Clk);
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge Clk);
        check("drain_empty", q.size(), 0);
        check("no_loss_dup", retires, accepts);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
